// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared FSM encoding, slot-field location and slot map for the peripheral bus
package periph_bus_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    localparam int SLOT_MSB = 7;
    localparam int SLOT_LSB = 6;

    localparam int SLOT_KEYBOARD = 0;
    localparam int SLOT_DISPLAY  = 1;
    localparam int SLOT_RAM      = 2;
    localparam int SLOT_SPARE    = 3;

    function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
        return 4'b0001 << slot;
    endfunction

endpackage

// File: rtl/periph_bus_initiator_if.sv
// periph_bus_initiator_if: shared 8-bit peripheral bus between the initiator and its slaves
interface periph_bus_initiator_if #(
    parameter int NUM_PERIPH = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
);
    logic [NUM_PERIPH-1:0]        enable;
    logic [ADDR_W-1:0]            address;
    logic [DATA_W-1:0]            wdata;
    logic                         write;
    logic                         read;
    logic [NUM_PERIPH*DATA_W-1:0] rdata;

    modport master(output enable, address, wdata, write, read, input rdata);
    modport slave(input enable, address, wdata, write, read, output rdata);
endinterface

// File: rtl/periph_bus_initiator_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr; the pointer register lives in the parent
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0] valid,
    input  logic [1:0]   ptr,
    input  logic         accept,
    output logic [N-1:0] grant,
    output logic [1:0]   next_ptr
);
    int best;
    int pick;

    // Closest valid requester at or after ptr (modulo N) wins
    always_comb begin
        best     = N;
        pick     = 0;
        grant    = '0;
        next_ptr = ptr;
        for (int j = 0; j < N; j++) begin
            if (valid[j] && ((j - int'(ptr) + N) % N) < best) begin
                best = (j - int'(ptr) + N) % N;
                pick = j;
            end
        end
        for (int j = 0; j < N; j++) grant[j] = accept && best < N && pick == j;
        if (accept && best < N) next_ptr = 2'((pick + 1) % N);
    end
endmodule

// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator: arbitrates internal requesters onto the shared peripheral bus and returns responses
module periph_bus_initiator
    import periph_bus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_PERIPH = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [1:0]                rsp_id,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      busy,
    periph_bus_initiator_if.master    bus
);
    state_t              state;
    logic [1:0]          rr_ptr;
    logic [1:0]          next_ptr;
    logic [1:0]          gid;
    logic [1:0]          sel_id;
    logic [1:0]          slot;
    logic [NUM_REQ-1:0]  grant;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [DATA_W-1:0]   slot_rdata;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .accept   (state == IDLE && !rst),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign req_ready = grant;
    assign busy      = state != IDLE;
    assign slot      = bus.address[SLOT_MSB:SLOT_LSB];

    // Steer the granted requester's fields onto the bus load path
    always_comb begin
        sel_id    = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_id    = 2'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read data of the addressed slot; an unmapped slot reads as zero
    always_comb begin
        slot_rdata = '0;
        for (int p = 0; p < NUM_PERIPH; p++)
            if (slot == 2'(p)) slot_rdata = bus.rdata[p*DATA_W +: DATA_W];
    end

    // Transaction FSM: accept in IDLE, strobe for one ISSUE cycle, capture read data, pulse the response
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gid         <= '0;
            bus.enable  <= '0;
            bus.address <= '0;
            bus.wdata   <= '0;
            bus.write   <= 1'b0;
            bus.read    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    rr_ptr      <= next_ptr;
                    gid         <= sel_id;
                    bus.enable  <= NUM_PERIPH'(slot_onehot(sel_addr[SLOT_MSB:SLOT_LSB]));
                    bus.address <= sel_addr;
                    bus.wdata   <= sel_wdata;
                    bus.write   <= sel_write;
                    bus.read    <= !sel_write;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    bus.enable <= '0;
                    bus.write  <= 1'b0;
                    bus.read   <= 1'b0;
                    if (bus.write) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= gid;
                        rsp_rdata <= '0;
                    end
                    state <= bus.write ? RESP : CAPTURE;
                end
                CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= gid;
                    rsp_rdata <= slot_rdata;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_periph_bus_initiator.sv
// tb_periph_bus_initiator: directed and randomized checks against a timeline model of the bus initiator
module tb_periph_bus_initiator;
    localparam int NR = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, req_write = '0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_ready, rsp_id;
    logic        rsp_valid, busy;
    logic [7:0]  rsp_rdata;

    logic [1:0]  v2 = '0, w2 = '0;
    logic [15:0] a2 = '0, d2 = '0;
    logic [1:0]  ready2, rid2;
    logic        rv2, busy2;
    logic [7:0]  rd2;

    periph_bus_initiator_if #(.NUM_PERIPH(4)) bus ();
    periph_bus_initiator_if #(.NUM_PERIPH(2)) bus2 ();

    periph_bus_initiator dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .busy(busy), .bus(bus)
    );

    periph_bus_initiator #(.NUM_PERIPH(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_write(w2),
        .req_addr(a2), .req_wdata(d2), .req_ready(ready2),
        .rsp_valid(rv2), .rsp_id(rid2), .rsp_rdata(rd2),
        .busy(busy2), .bus(bus2)
    );

    assign bus2.rdata = 16'hBEEF;

    int total = 0, bad = 0, cyc = 0, rsp_pulses = 0, reads2 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Slave model: registered data_out per slot, memory keyed by full address
    logic [7:0] sdout[4];
    logic [7:0] smem[256];
    assign bus.rdata = {sdout[3], sdout[2], sdout[1], sdout[0]};
    initial begin
        for (int i = 0; i < 256; i++) smem[i] = 8'h00;
        for (int p = 0; p < 4; p++) sdout[p] = 8'h00;
        forever begin
            @(posedge clk);
            for (int p = 0; p < 4; p++) begin
                if (bus.enable[p] && bus.write) smem[bus.address] <= bus.wdata;
                if (bus.enable[p] && bus.read) sdout[p] <= smem[bus.address];
            end
        end
    end

    always @(negedge clk) if (bus2.read) reads2++;

    // Timeline model: an accept at cycle t0 shows strobes at t0+1 and a response at t0+2 (write) / t0+3 (read)
    initial begin
        int c, g, m_t0, m_free, m_ptr, m_gid;
        bit m_wr, armed, e_issue, e_rsp, e_busy;
        logic [7:0] m_addr, m_wd, exp_addr, exp_wd;
        logic [3:0] e_en;
        logic [1:0] e_ready;
        logic [7:0] ref_mem[256];
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        m_t0 = -100; m_free = 0; m_ptr = 0; m_gid = 0; m_wr = 0; armed = 0;
        m_addr = 0; m_wd = 0; exp_addr = 0; exp_wd = 0;
        forever begin
            @(negedge clk);
            c = cyc;
            e_issue = c == m_t0 + 1;
            if (e_issue) begin
                exp_addr = m_addr;
                exp_wd   = m_wd;
                if (m_wr) ref_mem[m_addr] = m_wd;
            end
            e_en   = e_issue ? 4'(4'b0001 << m_addr[7:6]) : 4'b0000;
            e_rsp  = c == m_t0 + (m_wr ? 2 : 3);
            e_busy = c > m_t0 && c < m_free;
            e_ready = '0;
            g = -1;
            if (!rst && c >= m_free)
                for (int k = 0; k < NR && g < 0; k++)
                    if (req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            if (g >= 0) e_ready[g] = 1'b1;
            if (armed) begin
                chk("m_ready", req_ready, e_ready);
                chk("m_busy", busy, e_busy);
                chk("m_enable", bus.enable, e_en);
                chk("m_write", bus.write, e_issue && m_wr);
                chk("m_read", bus.read, e_issue && !m_wr);
                chk("m_address", bus.address, exp_addr);
                chk("m_wdata", bus.wdata, exp_wd);
                chk("m_rsp_valid", rsp_valid, e_rsp);
                if (e_rsp) begin
                    chk("m_rsp_id", rsp_id, m_gid);
                    chk("m_rsp_rdata", rsp_rdata, m_wr ? 8'h00 : ref_mem[m_addr]);
                end
                chk("a_onehot_en", $onehot0(bus.enable), 1);
                chk("a_rw_excl", bus.read & bus.write, 0);
            end
            if (rsp_valid) rsp_pulses++;
            if (g >= 0) begin
                m_t0   = c;
                m_gid  = g;
                m_wr   = req_write[g];
                m_addr = req_addr[g*8 +: 8];
                m_wd   = req_wdata[g*8 +: 8];
                m_ptr  = (g + 1) % NR;
                m_free = c + (m_wr ? 3 : 4);
            end
            if (rst) begin
                armed = 1; m_t0 = -100; m_free = c + 1; m_ptr = 0;
                exp_addr = 0; exp_wd = 0;
            end
        end
    end

    task automatic do_req(input int i, input bit w, input logic [7:0] a, input logic [7:0] d, output int t);
        req_write[i] = w;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = d;
        req_valid[i] = 1'b1;
        t = -1;
        for (int n = 0; n < 60 && t < 0; n++) begin
            @(negedge clk);
            if (req_ready[i]) t = cyc;
        end
        total++;
        if (t < 0) begin
            bad++;
            $display("FAIL req%0d_accept_timeout cyc=%0d got=none want=ready", i, cyc);
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tp, r, p0, pr;
        bit act[NR], got[NR];
        // reset state, with requests pending that must not be accepted
        req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_enable", bus.enable, 0);
        chk("rst_strobes", {bus.write, bus.read}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;

        // single write then read-back of the same address
        do_req(0, 1, 8'h05, 8'hA5, t);
        @(negedge clk);
        chk("t1_en", bus.enable, 4'b0001);
        chk("t1_write", bus.write, 1);
        chk("t1_addr", bus.address, 8'h05);
        chk("t1_wdata", bus.wdata, 8'hA5);
        @(negedge clk);
        chk("t1_write_drop", bus.write, 0);
        chk("t1_wr_rsp", rsp_valid, 1);
        chk("t1_wr_rsp_id", rsp_id, 0);
        @(posedge clk); #1;
        tp = t;
        do_req(0, 0, 8'h05, 8'h00, t);
        chk("t1_wr_spacing", t - tp, 3);
        @(negedge clk);
        chk("t1_read", bus.read, 1);
        chk("t1_rd_en", bus.enable, 4'b0001);
        @(negedge clk);
        chk("t1_rd_early", rsp_valid, 0);
        @(negedge clk);
        chk("t1_rd_rsp", rsp_valid, 1);
        chk("t1_rd_data", rsp_rdata, 8'hA5);
        @(posedge clk); #1;

        // reset during CAPTURE of a req0 read; afterwards both requesters contend
        do_req(0, 0, 8'h40, 8'h00, t);
        @(posedge clk); #1;
        rst = 1'b1;
        req_write = 2'b00;
        req_addr = {8'h80, 8'h40};
        req_valid = 2'b11;
        @(negedge clk);
        chk("t5_busy_capture", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        r = cyc;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("t5_no_rsp", rsp_valid, 0);
                chk("t5_busy", busy, 0);
                chk("t5_outs_zero", {bus.enable, bus.address, bus.wdata, bus.write, bus.read, rsp_id, rsp_rdata}, 0);
            end
            chk("t2_ready", req_ready, (k % 4 != 0) ? 2'b00 : (k % 8 == 0) ? 2'b01 : 2'b10);
            if (k % 4 == 1) chk("t2_en", bus.enable, (k % 8 == 1) ? 4'b0010 : 4'b0100);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;

        // back-to-back writes by req1 into the spare slot
        p0 = rsp_pulses;
        tp = -1;
        for (int j = 0; j < 3; j++) begin
            do_req(1, 1, 8'hC0 + 8'(j), 8'(j * 17), t);
            if (tp >= 0) chk("t3_spacing", t - tp, 3);
            tp = t;
            @(negedge clk);
            chk("t3_en", bus.enable, 4'b1000);
            chk("t3_write", bus.write, 1);
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("t3_rsp_count", rsp_pulses - p0, 3);

        // randomized traffic, including requests withdrawn before ready
        for (int i = 0; i < NR; i++) begin act[i] = 0; got[i] = 0; end
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) got[i] = req_ready[i];
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (act[i] && (got[i] || $urandom_range(0, 11) == 0)) begin
                    act[i] = 0;
                    req_valid[i] = 1'b0;
                end
                if (!act[i] && n < 590 && $urandom_range(0, 2) == 0) begin
                    act[i] = 1;
                    req_write[i] = 1'($urandom_range(0, 1));
                    req_addr[i*8 +: 8] = {2'($urandom_range(0, 3)), 3'b000, 3'($urandom_range(0, 7))};
                    req_wdata[i*8 +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
        end
        req_valid = 2'b00;
        repeat (6) @(posedge clk);
        #1;

        // unmapped slot on a two-slot initiator
        pr = reads2;
        w2 = 2'b00;
        a2[7:0] = 8'hC3;
        v2 = 2'b01;
        @(negedge clk);
        chk("t4_ready", ready2, 2'b01);
        @(posedge clk); #1;
        v2 = 2'b00;
        @(negedge clk);
        chk("t4_en", bus2.enable, 2'b00);
        chk("t4_read", bus2.read, 1);
        chk("t4_busy", busy2, 1);
        @(negedge clk);
        chk("t4_read_drop", bus2.read, 0);
        chk("t4_rsp_early", rv2, 0);
        @(negedge clk);
        chk("t4_rsp", rv2, 1);
        chk("t4_rdata", rd2, 8'h00);
        chk("t4_rsp_id", rid2, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_read_pulses", reads2 - pr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
